// File: rtl/veto_err_pkg.sv
// Shared types and defaults for the veto error scanner and its phase timer.
package veto_err_pkg;

  localparam int N_SRC_DEF   = 29;
  localparam int W_SRC_DEF   = 8;
  localparam int BUS_W_DEF   = N_SRC_DEF * W_SRC_DEF;
  localparam int TIMEOUT_DEF = 255;
  localparam int SEL_W       = 5;

  // Wide enough to cover any practical word width; sliced to W_SRC at use.
  localparam logic [63:0] TIMEOUT_FILL = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_REL,
    ST_DONE,
    ST_HOLD
  } scan_state_e;

endpackage

// File: rtl/veto_err_slot_timer.sv
// Per-phase cycle counter. Expired asserts on the TIMEOUT-th cycle after a clear.
module veto_err_slot_timer
  import veto_err_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/veto_err_scanner.sv
// Polls N_SRC veto sources over a 4-phase req/ack port once per live period and
// emits one got_veto_err strobe. Optional per-phase timeout: VETO_ERR_SCAN_TIMEOUT_EN.
module veto_err_scanner
  import veto_err_pkg::*;
#(
  parameter int N_SRC   = N_SRC_DEF,
  parameter int W_SRC   = W_SRC_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_live,
  input  logic                   scan_req,
  output logic [SEL_W-1:0]       src_sel,
  output logic                   src_req,
  input  logic                   src_ack,
  input  logic [W_SRC-1:0]       src_data,
  output logic [N_SRC*W_SRC-1:0] veto_err_bus,
  output logic                   got_veto_err,
  output logic                   scan_busy,
  output logic [N_SRC-1:0]       timeout_mask
);

  localparam int               BUS_W    = N_SRC * W_SRC;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_SRC - 1);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] idx_q;
  logic [BUS_W-1:0] bus_q;
  logic [N_SRC-1:0] tmask_q;
  logic             phase_expired;

`ifdef VETO_ERR_SCAN_TIMEOUT_EN
  logic phase_clear, phase_en;

  // Restart the count on every state change, so each REQ/REL entry starts at 0.
  assign phase_clear = (state_d != state_q);
  assign phase_en    = (state_q == ST_REQ) || (state_q == ST_REL);

  veto_err_slot_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_slot_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (phase_clear),
    .en     (phase_en),
    .expired(phase_expired)
  );
`else
  assign phase_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    if (!in_live) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (scan_req) state_d = ST_REQ;
        ST_REQ:  if (src_ack || phase_expired) state_d = ST_REL;
        ST_REL: begin
          if (!src_ack || phase_expired)
            state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_REQ;
        end
        ST_DONE: state_d = ST_HOLD;
        ST_HOLD: state_d = ST_HOLD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    src_req      = (state_q == ST_REQ);
    scan_busy    = (state_q == ST_REQ) || (state_q == ST_REL);
    got_veto_err = (state_q == ST_DONE);
  end

  // NOTE: the error bus is a plain register bank, so it is reset like any other
  // state; a dropped live period must never leave stale words visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      bus_q   <= '0;
      tmask_q <= '0;
    end else if (!in_live) begin
      idx_q   <= '0;
      bus_q   <= '0;
      tmask_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (scan_req) begin
            idx_q   <= '0;
            bus_q   <= '0;
            tmask_q <= '0;
          end
        end
        ST_REQ: begin
          if (src_ack) begin
            bus_q[idx_q*W_SRC +: W_SRC] <= src_data;
          end else if (phase_expired) begin
            bus_q[idx_q*W_SRC +: W_SRC] <= TIMEOUT_FILL[W_SRC-1:0];
            tmask_q[idx_q]              <= 1'b1;
          end
        end
        ST_REL: begin
          if (!src_ack) begin
            if (idx_q != LAST_IDX) idx_q <= idx_q + SEL_W'(1);
          end else if (phase_expired) begin
            tmask_q[idx_q] <= 1'b1;
            if (idx_q != LAST_IDX) idx_q <= idx_q + SEL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign src_sel      = idx_q;
  assign veto_err_bus = bus_q;
  assign timeout_mask = tmask_q;

endmodule

// File: tb/tb_veto_err_scanner.sv
// Directed bench for veto_err_scanner; timeout scenarios run when
// VETO_ERR_SCAN_TIMEOUT_EN is defined.
module tb_veto_err_scanner;
  import veto_err_pkg::*;

  localparam int N = N_SRC_DEF;
  localparam int W = W_SRC_DEF;
`ifdef VETO_ERR_SCAN_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = TIMEOUT_DEF;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_live;
  logic             scan_req;
  logic [SEL_W-1:0] src_sel;
  logic             src_req;
  logic             src_ack;
  logic [W-1:0]     src_data;
  logic [BUS_W_DEF-1:0] veto_err_bus;
  logic             got_veto_err;
  logic             scan_busy;
  logic [N-1:0]     timeout_mask;

  // Source model controls
  int           never_idx;
  int           stuck_idx;
  logic         zero_data;
  logic [W-1:0] data_ofs;

  int n_checks;
  int n_errors;

  logic [BUS_W_DEF-1:0] exp_bus;
  int                   lat;
  int                   strobes;
  logic                 busy_at;

  veto_err_scanner #(
    .N_SRC  (N),
    .W_SRC  (W),
    .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_live     (in_live),
    .scan_req    (scan_req),
    .src_sel     (src_sel),
    .src_req     (src_req),
    .src_ack     (src_ack),
    .src_data    (src_data),
    .veto_err_bus(veto_err_bus),
    .got_veto_err(got_veto_err),
    .scan_busy   (scan_busy),
    .timeout_mask(timeout_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait responder: ack follows req; one source may be dead or stuck high.
  always_comb begin
    src_ack  = 1'b0;
    src_data = '0;
    if (int'(src_sel) == stuck_idx) begin
      src_ack  = 1'b1;
      src_data = 8'hA5;
    end else if (int'(src_sel) != never_idx) begin
      src_ack  = src_req;
      src_data = zero_data ? '0 : (W'(src_sel) + data_ofs);
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_scan();
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
  endtask

  task automatic build_exp(input logic [W-1:0] ofs, input logic zero);
    exp_bus = '0;
    for (int i = 0; i < N; i++) exp_bus[i*W +: W] = zero ? '0 : (W'(i) + ofs);
  endtask

  // Counts edges after the request edge until the strobe, then a few more.
  task automatic wait_scan(output int l, output int s, output logic b);
    l = -1;
    s = 0;
    b = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (got_veto_err) begin
        s++;
        if (l < 0) begin
          l = c;
          b = scan_busy;
        end
      end
      if (l >= 0 && c >= l + 4) break;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    never_idx = -1;
    stuck_idx = -1;
    zero_data = 1'b0;
    data_ofs  = '0;
    rst_n     = 1'b0;
    in_live   = 1'b0;
    scan_req  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset mid-scan
    in_live = 1'b1;
    pulse_scan();
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    check("rst_src_req", src_req, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_got", got_veto_err, 0);
    check("rst_sel", src_sel, 0);
    check("rst_bus", veto_err_bus, 0);
    check("rst_mask", timeout_mask, 0);
    rst_n = 1'b1;
    tick();
    check("rst_idle_no_req", src_req, 0);

    // Full zero-wait scan, slot i = i
    pulse_scan();
    check("start_req", src_req, 1);
    check("start_sel", src_sel, 0);
    check("start_busy", scan_busy, 1);
    wait_scan(lat, strobes, busy_at);
    build_exp(8'h00, 1'b0);
    check("scan1_latency", lat, 2 * N);
    check("scan1_strobes", strobes, 1);
    check("scan1_busy_at_strobe", busy_at, 0);
    check("scan1_bus", veto_err_bus, exp_bus);
    check("scan1_mask", timeout_mask, 0);

    // scan_req in HOLD is ignored
    pulse_scan();
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (got_veto_err || src_req) strobes++;
    end
    check("hold_ignored", strobes, 0);
    check("hold_bus_stable", veto_err_bus, exp_bus);

    // in_live drop clears, fresh scan with new data
    in_live = 1'b0;
    tick();
    check("drop_bus_clear", veto_err_bus, 0);
    check("drop_req", src_req, 0);
    in_live  = 1'b1;
    data_ofs = 8'h80;
    pulse_scan();
    wait_scan(lat, strobes, busy_at);
    build_exp(8'h80, 1'b0);
    check("scan2_latency", lat, 2 * N);
    check("scan2_strobes", strobes, 1);
    check("scan2_bus", veto_err_bus, exp_bus);

    // Abort while polling source 10
    in_live = 1'b0;
    tick();
    in_live  = 1'b1;
    data_ofs = 8'h00;
    pulse_scan();
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      if (src_req && src_sel == 5'd10) begin
        lat = c;
        break;
      end
      tick();
    end
    check("abort_reached_src10", (lat >= 0), 1);
    in_live = 1'b0;
    tick();
    check("abort_req", src_req, 0);
    check("abort_bus", veto_err_bus, 0);
    check("abort_busy", scan_busy, 0);
    check("abort_sel", src_sel, 0);
    strobes = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (got_veto_err) strobes++;
    end
    check("abort_no_strobe", strobes, 0);

    // scan_req with in_live low: abort wins, stays idle
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    check("req_vs_drop", src_req, 0);

`ifdef VETO_ERR_SCAN_TIMEOUT_EN
    // Source 3 dead: REQ times out after 4 cycles (+3 vs a zero-wait slot)
    never_idx = 3;
    zero_data = 1'b1;
    in_live   = 1'b1;
    pulse_scan();
    wait_scan(lat, strobes, busy_at);
    build_exp(8'h00, 1'b1);
    exp_bus[3*W +: W] = 8'hFF;
    check("to_req_latency", lat, 2 * N + 3);
    check("to_req_strobes", strobes, 1);
    check("to_req_bus", veto_err_bus, exp_bus);
    check("to_req_mask", timeout_mask, 29'h0000_0008);

    // Source 5 ack stuck high: REL times out, captured word kept
    in_live = 1'b0;
    tick();
    never_idx = -1;
    stuck_idx = 5;
    zero_data = 1'b0;
    in_live   = 1'b1;
    pulse_scan();
    wait_scan(lat, strobes, busy_at);
    build_exp(8'h00, 1'b0);
    exp_bus[5*W +: W] = 8'hA5;
    check("to_rel_latency", lat, 2 * N + 3);
    check("to_rel_strobes", strobes, 1);
    check("to_rel_bus", veto_err_bus, exp_bus);
    check("to_rel_mask", timeout_mask, 29'h0000_0020);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
